lsu_dmem: RTL
=============

Name: lsu_dmem

Overview:
- Parametrised data-memory unit with load/store sub-word support. Generational successor to the word-only data memory.
- Accepts one request through a valid/ready handshake. Performs RV32I byte, halfword and word loads and stores, little-endian, with sign or zero extension.
- Inserts a configurable number of wait states and returns a one-cycle response pulse with an error flag.
- Sits between the execute stage (ALU address result, rs2 data, funct3) and write-back.

Parameters:
- XLEN, 32, data width in bits; only 32 supported.
- DEPTH_WORDS, 64, number of XLEN-bit words; power of two, 4..4096.
- LATENCY, 1, wait-state cycles between acceptance and access; 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; rs2, LSB-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal funct3; valid with rsp_valid.

Behaviour:
- Reset values: req_ready=0 while rst is high, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, wait counter=0. Every memory word is cleared to 0.
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready=1. On a clock edge with req_valid=1, capture we, funct3, addr and wdata, load counter=LATENCY, and go to WAIT.
- WAIT: req_ready=0. If counter!=0, decrement it. If counter==0, perform the access at this edge: write the masked lanes, or register the extended read data. Then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; req_ready=0; go to IDLE on the next edge. There is no response back-pressure.
- Timing: a request accepted at edge k raises rsp_valid after edge k+LATENCY+1, sampled high at edge k+LATENCY+2. The earliest next acceptance is edge k+LATENCY+3.
- Word index = addr[2+log2(DEPTH_WORDS)-1:2]. If addr bits above that range are not all zero, the access is out of range: set rsp_err=1.
- Loads:
  - funct3 000 LB: sign-extend byte addr[1:0].
  - 100 LBU: zero-extend that byte.
  - 001 LH: sign-extend halfword addr[1].
  - 101 LHU: zero-extend that halfword.
  - 010 LW: full word.
- Stores:
  - 000 SB: write wdata[7:0] into byte lane addr[1:0].
  - 001 SH: write wdata[15:0] into halfword lane addr[1].
  - 010 SW: write the full word.
  - Other lanes are unchanged.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Errors (misaligned, out of range, any other funct3, or store funct3 >=011):
  - No memory write occurs. Response timing is unchanged, with rsp_err=1 and rsp_rdata=0.
- Stores return rsp_rdata=0 and rsp_err=0 on success.
- req_valid while req_ready=0 is ignored and not queued; the requester must hold it.
- Reset mid-operation aborts the request: no write, no response. Memory is cleared.
- A load following a store to the same word returns the newly written data; there are no hazards because requests are strictly serialised.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - The FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- One combinational sub-module, lsu_lane_align. It takes funct3, addr[1:0], wdata and the memory word, and produces:
  - the 4-bit byte-write mask,
  - the merged write word,
  - the extended load data,
  - the misalign/illegal flag.
- The top module keeps the FSM, counter, storage array and range check.

Test Plan:
- LATENCY=0: SW addr 0x10 wdata 0xDEADBEEF accepted at edge k, so rsp_valid is high at edge k+2 with rsp_err=0. Then LW 0x10 returns rsp_rdata=0xDEADBEEF.
- SB 0x11 wdata 0x80, then LB 0x11 returns 0xFFFFFF80 and LBU 0x11 returns 0x00000080. LW 0x10 returns 0xDEAD80EF.
- SH 0x22 wdata 0x8001, then LH 0x22 returns 0xFFFF8001, LHU 0x22 returns 0x00008001, and LW 0x20 returns 0x80010000.
- Errors, each giving rsp_err=1 and rsp_rdata=0 with no memory change:
  - LW 0x13 (misaligned).
  - SW 0x100 with DEPTH_WORDS=64 (out of range).
  - funct3 011 load (illegal).
- LATENCY=3: accept at edge k gives rsp_valid at edge k+5 only. req_ready=0 from after edge k through edge k+5, and req_valid toggling during that window is ignored.
- Assert rst two cycles after accepting SW 0x0 wdata 0x1234 with LATENCY=3: rsp_valid is never raised. After release, LW 0x0 returns 0 and req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store data-memory unit.
package lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request captured at acceptance and held until the access edge
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store merge, load extraction/extension, alignment and funct3 legality.
module lsu_lane_align #(
    parameter int XLEN = 32
) (
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] word,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wword,
    output logic [XLEN-1:0] ldata,
    output logic            err
);
    import lsu_pkg::*;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] wsh;

    // Decode size/sign, pick the addressed lane and replicate store data across lanes
    always_comb begin
        byte_sel = word[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        be       = 4'b0000;
        wsh      = wdata;
        ldata    = '0;
        err      = 1'b0;
        case (funct3)
            F3_B: begin
                be    = 4'b0001 << addr_lo;
                wsh   = {4{wdata[7:0]}};
                ldata = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                err   = addr_lo[0];
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wsh   = {2{wdata[15:0]}};
                ldata = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                err   = (addr_lo != 2'b00);
                be    = 4'b1111;
                ldata = word;
            end
            // unsigned variants exist only for loads
            F3_BU: begin
                err   = we;
                ldata = {24'b0, byte_sel};
            end
            F3_HU: begin
                err   = we | addr_lo[0];
                ldata = {16'b0, half_sel};
            end
            default: err = 1'b1;
        endcase
        // a faulting access must not touch any lane
        if (err || !we) be = 4'b0000;
    end

    // Merge the enabled lanes of the store data into the existing word
    always_comb begin
        for (int i = 0; i < 4; i++)
            wword[8*i +: 8] = be[i] ? wsh[8*i +: 8] : word[8*i +: 8];
    end

endmodule

// File: rtl/lsu_dmem.sv
// Data memory with RV32I sub-word loads/stores, programmable wait states and a one-cycle response.
module lsu_dmem #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);
    import lsu_pkg::*;

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t          state;
    logic [3:0]      cnt;
    lsu_req_t        req_q;
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic            oor;
    logic [XLEN-1:0] word;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wword;
    logic [XLEN-1:0] al_ldata;
    logic            al_err;
    logic            err;

    assign idx  = req_q.addr[AW+1:2];
    // any address bit above the word index means the access falls outside the array
    assign oor  = |req_q.addr[XLEN-1:AW+2];
    assign word = mem[idx];
    assign err  = al_err | oor;

    // ready only while idle and out of reset
    assign req_ready = (state == IDLE) && !rst;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .we      (req_q.we),
        .funct3  (req_q.funct3),
        .addr_lo (req_q.addr[1:0]),
        .wdata   (req_q.wdata),
        .word    (word),
        .be      (al_be),
        .wword   (al_wword),
        .ldata   (al_ldata),
        .err     (al_err)
    );

    // Request FSM, wait counter, storage and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q <= '{we: req_we, funct3: req_funct3,
                                   addr: req_addr, wdata: req_wdata};
                        cnt   <= 4'(LATENCY);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (req_q.we && !err && (|al_be)) mem[idx] <= al_wword;
                        rsp_rdata <= (!req_q.we && !err) ? al_ldata : '0;
                        rsp_err   <= err;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
